// File: rtl/mem_pkg.sv
// Shared definitions for the four-bank word memory: bank geometry, defaults,
// address decode and the request legality rule also used by the cache side.
package mem_pkg;

  localparam int unsigned NUM_BANKS         = 4;
  localparam int unsigned BANK_BUSY_DEFAULT = 4;
  localparam int unsigned READ_LAT_DEFAULT  = 2;
  localparam int unsigned MAX_ADDR_W        = 32;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_READ,
    REQ_WRITE,
    REQ_ILLEGAL
  } req_kind_t;

  // Words are interleaved across banks on addr[2:1]; the row is the rest above.
  function automatic logic [1:0] bank_of(input logic [MAX_ADDR_W-1:0] addr);
    return 2'(addr >> 1);
  endfunction

  function automatic logic [MAX_ADDR_W-4:0] row_of(input logic [MAX_ADDR_W-1:0] addr);
    return (MAX_ADDR_W-3)'(addr >> 3);
  endfunction

  function automatic logic req_illegal(input logic rd, input logic wr, input logic a0);
    return (rd & wr) | ((rd | wr) & a0);
  endfunction

  function automatic req_kind_t classify(input logic rd, input logic wr, input logic a0);
    if (req_illegal(rd, wr, a0)) return REQ_ILLEGAL;
    if (rd)                      return REQ_READ;
    if (wr)                      return REQ_WRITE;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One memory bank: word storage, read-data capture register and the
// occupancy counter that keeps the bank busy after each accepted access.
module mem_bank #(
  parameter int unsigned ROW_W     = 13,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BANK_BUSY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              we,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int unsigned       CNT_W    = $clog2(BANK_BUSY);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BANK_BUSY - 1);

  logic [DATA_W-1:0] mem [2**ROW_W];
  logic [CNT_W-1:0]  cnt;

  // Storage is deliberately not reset; accept already excludes reset cycles.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (we) begin
        mem[row] <= wdata;
      end else begin
        rdata <= mem[row];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/four_bank_mem_resp.sv
// Memory responder below the cache: four interleaved banks, one request per
// cycle, busy-bank stall, and a fixed-latency in-order read return path.
module four_bank_mem_resp
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BANK_BUSY = BANK_BUSY_DEFAULT,
  parameter int unsigned READ_LAT  = READ_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              createdump,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int unsigned ROW_W = ADDR_W - 3;

  req_kind_t             kind;
  logic [1:0]            bank;
  logic [ROW_W-1:0]      row;
  logic                  legal;
  logic                  accept;
  logic                  rd_accept;
  logic [NUM_BANKS-1:0]  bank_busy;
  logic [NUM_BANKS-1:0]  bank_accept;
  logic [DATA_W-1:0]     bank_rdata [NUM_BANKS];

  logic [READ_LAT-1:0]   vld_q;
  logic [1:0]            bank_q;
  logic [DATA_W-1:0]     head_data;
  logic [DATA_W-1:0]     tail_data;

  // The dump hook has no architectural effect.
  logic unused_dump;
  assign unused_dump = createdump;

  always_comb begin
    kind      = classify(rd, wr, addr[0]);
    bank      = bank_of(MAX_ADDR_W'(addr));
    row       = ROW_W'(row_of(MAX_ADDR_W'(addr)));
    legal     = (kind == REQ_READ) || (kind == REQ_WRITE);
    accept    = legal & ~bank_busy[bank] & ~rst;
    rd_accept = accept & (kind == REQ_READ);
    stall     = legal & bank_busy[bank] & ~rst;
    err       = (kind == REQ_ILLEGAL) & ~rst;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_accept[b] = accept && (bank == 2'(b));
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mem_bank #(
      .ROW_W    (ROW_W),
      .DATA_W   (DATA_W),
      .BANK_BUSY(BANK_BUSY)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .accept(bank_accept[g]),
      .we    (wr),
      .row   (row),
      .wdata (data_in),
      .rdata (bank_rdata[g]),
      .busy  (bank_busy[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      bank_q <= '0;
    end else begin
      vld_q[0] <= rd_accept;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      bank_q <= bank;
    end
  end

  // Bank capture registers hold the word only one cycle before the bank can be
  // re-read, so it is moved into the shared pipeline right after capture.
  assign head_data = bank_rdata[bank_q];

  if (READ_LAT == 1) begin : g_lat1
    assign tail_data = head_data;
  end else begin : g_latn
    logic [DATA_W-1:0] dat_q [READ_LAT-1];
    always_ff @(posedge clk) begin
      dat_q[0] <= head_data;
      for (int unsigned i = 1; i < READ_LAT - 1; i++) begin
        dat_q[i] <= dat_q[i-1];
      end
    end
    assign tail_data = dat_q[READ_LAT-2];
  end

  assign data_valid = vld_q[READ_LAT-1] & ~rst;
  assign data_out   = data_valid ? tail_data : '0;
  assign busy       = bank_busy & {NUM_BANKS{~rst}};

endmodule

// File: tb/tb_four_bank_mem_resp.sv
// Bench for four_bank_mem_resp: a fixed vector table, a reset corner sequence
// and random traffic, all scored against a timestamp-based memory model.
module tb_four_bank_mem_resp;

  localparam int BB = 4;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        createdump = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  four_bank_mem_resp #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .BANK_BUSY(BB),
    .READ_LAT (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .createdump(createdump),
    .addr      (addr),
    .data_in   (data_in),
    .rd        (rd),
    .wr        (wr),
    .data_out  (data_out),
    .data_valid(data_valid),
    .stall     (stall),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rd, wr;
    logic [15:0] addr, din;
    logic        e_stall, e_err, e_vld;
    logic [15:0] e_dout;
    logic [3:0]  e_busy;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } pend_t;

  vec_t        tbl[$];
  pend_t       pend[$];
  logic [15:0] mdl_mem[int];
  int          free_at[4];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic        s_stall, s_err, s_vld;
  logic [15:0] s_dout;
  logic [3:0]  s_busy;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input logic r, input logic rd_i, input logic wr_i,
                     input logic [15:0] a, input logic [15:0] d,
                     input logic st, input logic er, input logic v,
                     input logic [15:0] dout, input logic [3:0] b);
    vec_t e;
    e.rst = r; e.rd = rd_i; e.wr = wr_i; e.addr = a; e.din = d;
    e.e_stall = st; e.e_err = er; e.e_vld = v; e.e_dout = dout; e.e_busy = b;
    tbl.push_back(e);
  endtask

  task automatic idle(input logic v, input logic [15:0] dout, input logic [3:0] b);
    add(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, v, dout, b);
  endtask

  // Drives one cycle, samples mid-cycle and scores against the model.
  task automatic step(input logic r, input logic rd_i, input logic wr_i,
                      input logic [15:0] a, input logic [15:0] d);
    logic        e_stall, e_err, e_vld;
    logic [15:0] e_dout;
    logic [3:0]  e_busy;
    int          b;
    rst = r; rd = rd_i; wr = wr_i; addr = a; data_in = d;
    createdump = 1'($urandom_range(0, 1));
    @(negedge clk);
    s_stall = stall; s_err = err; s_vld = data_valid; s_dout = data_out; s_busy = busy;

    e_stall = 1'b0; e_err = 1'b0; e_vld = 1'b0; e_dout = '0; e_busy = '0;
    for (int k = 0; k < 4; k++) e_busy[k] = !r && (cyc < free_at[k]);
    if (r) begin
      pend.delete();
      for (int k = 0; k < 4; k++) free_at[k] = 0;
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e_vld  = 1'b1;
        e_dout = pend[0].data;
        void'(pend.pop_front());
      end
      e_err = (rd_i && wr_i) || ((rd_i || wr_i) && a[0]);
      if ((rd_i != wr_i) && !a[0]) begin
        b = int'(a[2:1]);
        if (cyc < free_at[b]) begin
          e_stall = 1'b1;
        end else begin
          free_at[b] = cyc + BB;
          if (rd_i) begin
            pend_t p;
            p.due  = cyc + RL;
            p.data = mdl_mem.exists(int'(a >> 1)) ? mdl_mem[int'(a >> 1)] : 16'h0;
            pend.push_back(p);
          end else begin
            mdl_mem[int'(a >> 1)] = d;
          end
        end
      end
    end
    chk("model_stall", 16'(s_stall), 16'(e_stall));
    chk("model_err",   16'(s_err),   16'(e_err));
    chk("model_valid", 16'(s_vld),   16'(e_vld));
    chk("model_dout",  s_dout,       e_dout);
    chk("model_busy",  16'(s_busy),  16'(e_busy));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) free_at[k] = 0;

    // Test-plan scenarios, one record per cycle.
    add(0,0,1,16'h0010,16'hBEEF,0,0,0,16'h0,4'b0000);
    idle(0,16'h0,4'b0001); idle(0,16'h0,4'b0001); idle(0,16'h0,4'b0001);
    add(0,1,0,16'h0010,16'h0,0,0,0,16'h0,4'b0000);
    idle(0,16'h0,4'b0001); idle(1,16'hBEEF,4'b0001); idle(0,16'h0,4'b0001);
    idle(0,16'h0,4'b0000);
    add(0,0,1,16'h0020,16'h0001,0,0,0,16'h0,4'b0000);
    add(0,0,1,16'h0022,16'h0002,0,0,0,16'h0,4'b0001);
    add(0,0,1,16'h0024,16'h0003,0,0,0,16'h0,4'b0011);
    add(0,0,1,16'h0026,16'h0004,0,0,0,16'h0,4'b0111);
    add(0,1,0,16'h0020,16'h0,0,0,0,16'h0,4'b1110);
    add(0,1,0,16'h0022,16'h0,0,0,0,16'h0,4'b1101);
    add(0,1,0,16'h0024,16'h0,0,0,1,16'h0001,4'b1011);
    add(0,1,0,16'h0026,16'h0,0,0,1,16'h0002,4'b0111);
    idle(1,16'h0003,4'b1110); idle(1,16'h0004,4'b1100); idle(0,16'h0,4'b1000);
    add(0,0,1,16'h0030,16'h3333,0,0,0,16'h0,4'b0000);
    add(0,1,0,16'h0038,16'h0,1,0,0,16'h0,4'b0001);
    add(0,1,0,16'h0038,16'h0,1,0,0,16'h0,4'b0001);
    add(0,1,0,16'h0038,16'h0,1,0,0,16'h0,4'b0001);
    add(0,1,0,16'h0038,16'h0,0,0,0,16'h0,4'b0000);
    idle(0,16'h0,4'b0001); idle(1,16'h0000,4'b0001); idle(0,16'h0,4'b0001);
    idle(0,16'h0,4'b0000);
    add(0,1,0,16'h0011,16'h0,0,1,0,16'h0,4'b0000);
    add(0,1,1,16'h0010,16'h5555,0,1,0,16'h0,4'b0000);
    add(0,0,1,16'h0013,16'h7777,0,1,0,16'h0,4'b0000);
    idle(0,16'h0,4'b0000);
    add(0,1,0,16'h0010,16'h0,0,0,0,16'h0,4'b0000);
    idle(0,16'h0,4'b0001); idle(1,16'hBEEF,4'b0001); idle(0,16'h0,4'b0001);
    add(0,1,0,16'h0010,16'h0,0,0,0,16'h0,4'b0000);
    add(1,0,0,16'h0,16'h0,0,0,0,16'h0,4'b0000);
    idle(0,16'h0,4'b0000);
    add(0,1,0,16'h0010,16'h0,0,0,0,16'h0,4'b0000);
    idle(0,16'h0,4'b0001); idle(1,16'hBEEF,4'b0001); idle(0,16'h0,4'b0001);
    add(0,0,1,16'h0040,16'h1111,0,0,0,16'h0,4'b0000);
    add(0,1,0,16'h0042,16'h0,0,0,0,16'h0,4'b0001);
    idle(0,16'h0,4'b0011); idle(1,16'h0000,4'b0011);
    add(0,1,0,16'h0040,16'h0,0,0,0,16'h0,4'b0010);
    idle(0,16'h0,4'b0001); idle(1,16'h1111,4'b0001); idle(0,16'h0,4'b0001);
    idle(0,16'h0,4'b0000);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    // Give every word the bench may read a known value.
    for (int a = 0; a <= 16'h46; a += 2) step(1'b0, 1'b0, 1'b1, 16'(a), 16'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      step(v.rst, v.rd, v.wr, v.addr, v.din);
      chk($sformatf("vec%0d_stall", i), 16'(s_stall), 16'(v.e_stall));
      chk($sformatf("vec%0d_err", i),   16'(s_err),   16'(v.e_err));
      chk($sformatf("vec%0d_valid", i), 16'(s_vld),   16'(v.e_vld));
      chk($sformatf("vec%0d_dout", i),  s_dout,       v.e_dout);
      chk($sformatf("vec%0d_busy", i),  16'(s_busy),  16'(v.e_busy));
    end

    // A write presented while rst is high must not land.
    step(1'b1, 1'b0, 1'b1, 16'h0044, 16'hAAAA);
    chk("rst_wr_err", 16'(s_err), 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0044, 16'h0);
    chk("rst_wr_rd_stall", 16'(s_stall), 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rst_wr_valid", 16'(s_vld), 16'h1);
    chk("rst_wr_data", s_dout, 16'h0000);

    for (int i = 0; i < 3000; i++) begin
      logic        r, rd_i, wr_i;
      int unsigned op;
      r  = ($urandom_range(0, 99) == 0);
      op = $urandom_range(0, 9);
      rd_i = (op <= 3) || (op == 7);
      wr_i = (op >= 4 && op <= 7);
      step(r, rd_i, wr_i, 16'($urandom_range(0, 71)), 16'($urandom));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/four_bank_mem_resp.md
Name: four_bank_mem_resp

Overview:
- Responder end of the word-level memory interface driven by the cache controller: four interleaved banks, pipelined reads with fixed latency, per-bank busy tracking.
- Accepts one read or write request per cycle and rejects requests to a busy bank with stall, so the requester must retry.
- Sits below the cache as main memory. Replaces the behavioural memory model with synthesizable RTL.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- BANK_BUSY, 4, cycles a bank stays occupied per access, counting the accept cycle; range 2..8
- READ_LAT, 2, cycles from accepted read to data_out valid; range 1..4

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- createdump  in  1  simulation dump hook; no effect on architectural state or outputs
- addr  in  ADDR_W  byte address; bank = addr[2:1], row = addr[ADDR_W-1:3]
- data_in  in  DATA_W  write data
- rd  in  1  read request, held by requester until accepted
- wr  in  1  write request, held by requester until accepted
- data_out  out  DATA_W  read data; valid only in the READ_LAT cycle after accept, 0 otherwise
- data_valid  out  1  high in the cycle data_out is valid
- stall  out  1  combinational; a legal request hit a busy bank and is not accepted
- busy  out  4  per-bank occupied flags, registered
- err  out  1  combinational; illegal request this cycle

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - clears busy counters, the read pipeline, data_out and data_valid.
  - While rst is high, stall, err, data_valid and busy read 0 and data_out reads 0.
  - Memory contents are not altered by reset. Simulation initial value of every word is 0.
- Legality:
  - A request is illegal if rd&wr, or if (rd|wr)&addr[0].
  - An illegal request gives err=1 and stall=0, and is never accepted: no bank state change, no data returned.
- Acceptance in cycle T: (rd^wr) & ~addr[0] & ~busy[bank] & ~rst.
- Stall: stall = (rd^wr) & ~addr[0] & busy[bank]. Never asserted together with err.
- Busy counter:
  - On accept, the bank counter loads BANK_BUSY-1.
  - busy[b] = (counter != 0). The counter decrements each cycle to 0 and saturates there.
  - busy[bank] is therefore 1 in cycles T+1..T+BANK_BUSY-1. The next accept to the same bank is possible at T+BANK_BUSY.
  - Counter width is clog2(BANK_BUSY).
- Write: the array is updated at the clock edge ending cycle T. A read accepted at T+1 or later returns the new value.
- Read:
  - The array word is captured at the edge ending T (read-before-any-later-write semantics) and carried through a READ_LAT-deep valid/data shift pipeline.
  - data_out and data_valid are presented in cycle T+READ_LAT.
- Pipelining:
  - Requests to distinct banks may be accepted on consecutive cycles. The four-word line fill 0,2,4,6 completes with no stall when BANK_BUSY<=4.
  - Returned reads stay in accept order, one per cycle.
- Simultaneous events:
  - A counter reaching 0 in cycle T-1 makes busy=0 in T, so the bank accepts in T.
  - A rejected (stalled) request does not reload or extend the counter.
- Reset mid-operation: reads in flight are discarded, and no data_valid follows reset. A write accepted in the same cycle rst is high is not performed.
- No internal FSM beyond per-bank counters and the read shift pipeline.

Decomposition:
- Shared package mem_pkg holds:
  - NUM_BANKS=4
  - default BANK_BUSY and READ_LAT
  - the bank-select and row-index functions of addr
  - the legality predicate, shared with the cache controller assertions.
- Sub-module mem_bank, instantiated 4x, contains:
  - storage of 2^(ADDR_W-3) words
  - the busy counter
  - an accept input, and captured read data out
- The top level contains:
  - bank decode
  - legality, stall and err logic
  - the read-latency pipeline and data_out mux.

Test Plan:
1. wr 0x0010 data 0xBEEF at T; rd 0x0010 at T+4 -> stall=0 both; data_valid=1, data_out=0xBEEF at T+6; data_out=0 at T+5 and T+7.
2. wr 0x0020..0x0026 (data 1,2,3,4) on four consecutive cycles, then rd the same four consecutively -> no stall; data_out 1,2,3,4 on consecutive cycles starting 2 after the first rd.
3. wr 0x0030 at T, rd 0x0038 held from T+1 -> busy[0]=1 at T+1..T+3; stall=1 at T+1..T+3; accepted at T+4 (stall=0); data at T+6.
4. rd 0x0011 -> err=1, stall=0, busy unchanged, no data_valid; rd=wr=1 at 0x0010 -> err=1, memory word unchanged (later read returns 0xBEEF).
5. rd 0x0010 at T, rst at T+1 -> data_valid=0 and data_out=0 at T+2; busy=4'b0000 at T+2; a following rd 0x0010 returns 0xBEEF (contents survive reset).
6. wr 0x0040=0x1111 at T and rd 0x0042 at T+1 (different banks) -> both accepted; rd 0x0040 at T+4 returns 0x1111; createdump toggled throughout with no effect.
